box_reduce: RTL and testbench



---
 rtl/box_reduce_if.sv | 37 +++
 rtl/box_reduce.sv | 215 +++++++++++++++++++++
 tb/tb_box_reduce.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/box_reduce_if.sv
// Handshake and box-count RAM bus between the box-reduction engine (slave) and
// its controller/RAM side (master).
interface box_reduce_if #(
   parameter int GRID_LOG = 3,
   parameter int DATA_LEN = 8
);
   logic                  start;
   logic                  abort;
   logic                  mode;
   logic [GRID_LOG:0]     cfg_levels;
   logic                  rd_en;
   logic [2*GRID_LOG:0]   rd_addr;
   logic [DATA_LEN-1:0]   rd_data;
   logic                  wr_en;
   logic [2*GRID_LOG:0]   wr_addr;
   logic [DATA_LEN-1:0]   wr_data;
   logic                  busy;
   logic                  done;
   logic                  level_valid;
   logic [GRID_LOG:0]     level_idx;
   logic [2*GRID_LOG-1:0] level_count;
   logic [1:0]            state_dbg;

   // start is a one-cycle request taken only in IDLE; done is a one-cycle
   // pulse; RAM read data is valid the cycle after rd_en; writes need no ack.
   modport slave (
      input  start, abort, mode, cfg_levels, rd_data,
      output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done,
             level_valid, level_idx, level_count, state_dbg
   );

   modport master (
      output start, abort, mode, cfg_levels, rd_data,
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done,
             level_valid, level_idx, level_count, state_dbg
   );
endinterface

// File: rtl/box_reduce.sv
// Multi-level 2x2 box-reduction engine: reads quads from one RAM bank, writes
// the reduced value to the other, level by level, with a per-level count.
module box_reduce #(
   parameter int GRID_LOG = 3,
   parameter int DATA_LEN = 8
) (
   input  logic       CLK,
   input  logic       RST,
   box_reduce_if.slave bus
);
   localparam int AW = 2*GRID_LOG + 1;
   localparam int LW = GRID_LOG + 1;
   localparam int CW = 2*GRID_LOG;
   localparam int SW = DATA_LEN + 2;

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t                state;
   logic                  mode_q;
   logic [LW-1:0]         levels_q;
   logic [LW-1:0]         k;
   logic [GRID_LOG-1:0]   r, c;
   logic [1:0]            w;
   logic                  drain_cnt;
   logic                  rd_en_q;
   logic [AW-1:0]         rd_addr_q;
   logic                  p_v;
   logic [1:0]            p_w;
   logic [GRID_LOG-1:0]   p_r, p_c;
   logic                  p_last;
   logic [SW-1:0]         acc;
   logic                  wr_en_q;
   logic [AW-1:0]         wr_addr_q;
   logic [DATA_LEN-1:0]   wr_data_q;
   logic                  busy_q, done_q, lv_q;
   logic [LW-1:0]         lv_idx_q;
   logic [CW-1:0]         lv_cnt_q;

   logic [GRID_LOG-1:0]   s_last;
   logic                  last_col, last_quad, last_read;
   logic [GRID_LOG-1:0]   r_n, c_n;
   logic [1:0]            w_n;
   logic [SW-1:0]         sum_n;
   logic [DATA_LEN-1:0]   res;
   logic [LW-1:0]         levels_in;

   function automatic logic [AW-1:0] mk_addr(input logic bank,
                                             input logic [GRID_LOG-1:0] rr,
                                             input logic [GRID_LOG-1:0] cc,
                                             input logic [1:0] ww);
      logic [GRID_LOG-1:0] row, col;
      row = (rr << 1) | GRID_LOG'(ww[1]);
      col = (cc << 1) | GRID_LOG'(ww[0]);
      return {bank, row, col};
   endfunction

   // Output side of level k is 2^(GRID_LOG-k), so the last index is all-ones >> k.
   assign s_last    = {GRID_LOG{1'b1}} >> k;
   assign last_col  = (c == s_last);
   assign last_quad = (r == s_last) && last_col;
   assign last_read = (w == 2'd3) && last_quad;
   assign levels_in = (bus.cfg_levels == '0 || bus.cfg_levels > LW'(GRID_LOG))
                      ? LW'(GRID_LOG) : bus.cfg_levels;
   assign sum_n     = (p_w == 2'd0) ? {2'b00, bus.rd_data}
                                    : acc + {2'b00, bus.rd_data};

   always_comb begin
      w_n = w + 2'd1;
      r_n = r;
      c_n = c;
      if (w == 2'd3) begin
         if (last_col) begin
            c_n = '0;
            r_n = r + GRID_LOG'(1);
         end else begin
            c_n = c + GRID_LOG'(1);
         end
      end
   end

   always_comb begin
      res = '0;
      if (mode_q)
         res = (sum_n != '0) ? DATA_LEN'(1) : '0;
      else if (|sum_n[SW-1:DATA_LEN])
         res = '1;
      else
         res = sum_n[DATA_LEN-1:0];
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         mode_q    <= 1'b0;
         levels_q  <= '0;
         k         <= '0;
         r         <= '0;
         c         <= '0;
         w         <= '0;
         drain_cnt <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         p_v       <= 1'b0;
         p_w       <= '0;
         p_r       <= '0;
         p_c       <= '0;
         p_last    <= 1'b0;
         acc       <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         lv_q      <= 1'b0;
         lv_idx_q  <= '0;
         lv_cnt_q  <= '0;
      end else if (bus.abort) begin
         state   <= IDLE;
         rd_en_q <= 1'b0;
         wr_en_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         lv_q    <= 1'b0;
         p_v     <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         done_q  <= 1'b0;
         lv_q    <= 1'b0;

         // Tag the outstanding read so its data can be combined next cycle.
         p_v    <= rd_en_q;
         p_w    <= w;
         p_r    <= r;
         p_c    <= c;
         p_last <= last_quad;

         if (p_v) begin
            acc <= sum_n;
            if (p_w == 2'd3) begin
               wr_en_q   <= 1'b1;
               wr_data_q <= res;
               wr_addr_q <= {k[0], p_r, p_c};
               lv_cnt_q  <= lv_cnt_q + CW'(res != '0);
               if (p_last) begin
                  lv_q     <= 1'b1;
                  lv_idx_q <= k;
               end
            end
         end

         case (state)
            IDLE: begin
               if (bus.start) begin
                  mode_q    <= bus.mode;
                  levels_q  <= levels_in;
                  k         <= LW'(1);
                  r         <= '0;
                  c         <= '0;
                  w         <= '0;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= mk_addr(1'b0, '0, '0, 2'd0);
                  busy_q    <= 1'b1;
                  lv_cnt_q  <= '0;
                  state     <= READ;
               end
            end
            READ: begin
               if (last_read) begin
                  rd_en_q   <= 1'b0;
                  drain_cnt <= 1'b0;
                  state     <= DRAIN;
               end else begin
                  w         <= w_n;
                  r         <= r_n;
                  c         <= c_n;
                  rd_addr_q <= mk_addr(~k[0], r_n, c_n, w_n);
               end
            end
            DRAIN: begin
               // Two idle read cycles let the level's last write land first.
               if (!drain_cnt) begin
                  drain_cnt <= 1'b1;
               end else if (k < levels_q) begin
                  k         <= k + LW'(1);
                  r         <= '0;
                  c         <= '0;
                  w         <= '0;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= mk_addr(k[0], '0, '0, 2'd0);
                  lv_cnt_q  <= '0;
                  state     <= READ;
               end else begin
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.rd_en       = rd_en_q;
   assign bus.rd_addr     = rd_addr_q;
   assign bus.wr_en       = wr_en_q;
   assign bus.wr_addr     = wr_addr_q;
   assign bus.wr_data     = wr_data_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.level_valid = lv_q;
   assign bus.level_idx   = lv_idx_q;
   assign bus.level_count = lv_cnt_q;
   assign bus.state_dbg   = state;
endmodule

// File: tb/tb_box_reduce.sv
// Directed bench for box_reduce on an 8x8 grid with a two-bank RAM model.
module tb_box_reduce;
   logic CLK;
   logic RST;
   int   cyc;
   int   base;
   int   n_cmp;
   int   n_fail;

   box_reduce_if #(.GRID_LOG(3), .DATA_LEN(8)) bus ();

   box_reduce #(.GRID_LOG(3), .DATA_LEN(8)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   logic [7:0] mem [0:127];

   logic [6:0] wa_q[$];
   logic [7:0] wd_q[$];
   int         wc_q[$];
   logic [6:0] ra_q[$];
   int         rc_q[$];
   int         li_q[$];
   int         lc_q[$];
   int         lvc_q[$];
   int         dc_q[$];
   logic       db_q[$];
   logic [7:0] exp_q[$];
   logic [6:0] exp_a_q[$];

   // clock / reset
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) cyc <= cyc + 1;

   // RAM model: registered read, write-after-read at the same edge
   always @(posedge CLK) begin
      if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
      if (bus.wr_en) mem[bus.wr_addr] = bus.wr_data;
   end

   // Event log, cycle numbers relative to the start edge (cycle 1 follows it)
   always @(negedge CLK) begin
      if (!RST) begin
         if (bus.wr_en) begin
            wa_q.push_back(bus.wr_addr); wd_q.push_back(bus.wr_data); wc_q.push_back(cyc - base);
         end
         if (bus.rd_en) begin
            ra_q.push_back(bus.rd_addr); rc_q.push_back(cyc - base);
         end
         if (bus.level_valid) begin
            li_q.push_back(int'(bus.level_idx)); lc_q.push_back(int'(bus.level_count));
            lvc_q.push_back(cyc - base);
         end
         if (bus.done) begin
            dc_q.push_back(cyc - base); db_q.push_back(bus.busy);
         end
      end
   end

   // driver tasks
   task automatic clear_logs();
      wa_q.delete(); wd_q.delete(); wc_q.delete(); ra_q.delete(); rc_q.delete();
      li_q.delete(); lc_q.delete(); lvc_q.delete(); dc_q.delete(); db_q.delete();
      exp_q.delete(); exp_a_q.delete();
   endtask

   task automatic fill(input logic [7:0] v);
      for (int i = 0; i < 64; i++) mem[i] = v;
      for (int i = 64; i < 128; i++) mem[i] = 8'h5A;
   endtask

   task automatic run(input logic m, input logic [3:0] lv);
      clear_logs();
      @(negedge CLK);
      bus.start = 1'b1; bus.mode = m; bus.cfg_levels = lv;
      @(posedge CLK);
      #1;
      base = cyc - 1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (!bus.done && n < budget) begin
         @(negedge CLK);
         n++;
      end
      n_cmp++;
      if (!bus.done) begin
         n_fail++; $display("FAIL done_timeout: no done within %0d cycles", budget);
      end
      @(negedge CLK);
      @(negedge CLK);
   endtask

   task automatic check_writes(input string name);
      n_cmp++;
      if (wa_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL %s_nwrites: got %0d want %0d", name, wa_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (wd_q[i] !== exp_q[i] || wa_q[i] !== exp_a_q[i]) begin
               n_fail++;
               $display("FAIL %s_write%0d: got addr %0d data %0d want addr %0d data %0d",
                        name, i, wa_q[i], wd_q[i], exp_a_q[i], exp_q[i]);
            end
         end
      end
   endtask

   // scenarios
   task automatic test_reset();
      RST = 1'b1;
      bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 1'b0; bus.cfg_levels = '0;
      repeat (3) @(negedge CLK);
      n_cmp++;
      if ({bus.rd_en, bus.wr_en, bus.busy, bus.done, bus.level_valid} !== 5'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b want 00000",
                            {bus.rd_en, bus.wr_en, bus.busy, bus.done, bus.level_valid});
      end
      n_cmp++;
      if (bus.rd_addr !== 7'd0 || bus.wr_addr !== 7'd0 || bus.wr_data !== 8'd0) begin
         n_fail++; $display("FAIL reset_bus: got ra %0d wa %0d wd %0d want 0 0 0",
                            bus.rd_addr, bus.wr_addr, bus.wr_data);
      end
      n_cmp++;
      if (bus.level_idx !== 4'd0 || bus.level_count !== 6'd0 || bus.state_dbg !== 2'd0) begin
         n_fail++; $display("FAIL reset_level: got idx %0d cnt %0d st %0d want 0 0 0",
                            bus.level_idx, bus.level_count, bus.state_dbg);
      end
      RST = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_ones_sum();
      int lat[3] = '{66, 84, 90};
      int cnt[3] = '{16, 4, 1};
      logic [6:0] first4[4] = '{7'd0, 7'd1, 7'd8, 7'd9};
      fill(8'h01);
      run(1'b0, 4'd3);
      wait_done(200);
      for (int lvl = 1; lvl <= 3; lvl++)
         for (int rr = 0; rr < (8 >> lvl); rr++)
            for (int cc = 0; cc < (8 >> lvl); cc++) begin
               exp_a_q.push_back(7'((lvl % 2) * 64 + rr * 8 + cc));
               exp_q.push_back(8'(4 ** lvl));
            end
      check_writes("ones");
      n_cmp++;
      if (lvc_q.size() !== 3 || dc_q.size() !== 1) begin
         n_fail++; $display("FAIL ones_events: got %0d levels %0d done want 3 1", lvc_q.size(), dc_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (lvc_q[i] !== lat[i] || lc_q[i] !== cnt[i] || li_q[i] !== i + 1) begin
               n_fail++; $display("FAIL ones_level%0d: got cyc %0d cnt %0d idx %0d want %0d %0d %0d",
                                  i + 1, lvc_q[i], lc_q[i], li_q[i], lat[i], cnt[i], i + 1);
            end
         end
         n_cmp++;
         if (dc_q[0] !== 91 || db_q[0] !== 1'b0) begin
            n_fail++; $display("FAIL ones_done: got cyc %0d busy %b want 91 0", dc_q[0], db_q[0]);
         end
      end
      n_cmp++;
      if (rc_q.size() !== 84) begin
         n_fail++; $display("FAIL ones_nreads: got %0d want 84", rc_q.size());
      end else begin
         n_cmp++;
         if (rc_q[0] !== 1 || rc_q[63] !== 64 || rc_q[64] !== 67 || rc_q[83] !== 88) begin
            n_fail++; $display("FAIL ones_read_cyc: got %0d %0d %0d %0d want 1 64 67 88",
                               rc_q[0], rc_q[63], rc_q[64], rc_q[83]);
         end
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (ra_q[i] !== first4[i]) begin
               n_fail++; $display("FAIL ones_read_addr%0d: got %0d want %0d", i, ra_q[i], first4[i]);
            end
         end
         n_cmp++;
         if (ra_q[64] !== 7'd64) begin
            n_fail++; $display("FAIL ones_l2_bank: got %0d want 64", ra_q[64]);
         end
      end
      n_cmp++;
      if (wc_q.size() < 2 || wc_q[0] !== 6 || wc_q[1] !== 10) begin
         n_fail++; $display("FAIL ones_write_cyc: got %0d writes, first cycles %0d %0d want 6 10",
                            wc_q.size(), wc_q.size() > 0 ? wc_q[0] : -1, wc_q.size() > 1 ? wc_q[1] : -1);
      end
   endtask

   task automatic test_saturate();
      fill(8'hFF);
      run(1'b0, 4'd1);
      wait_done(120);
      for (int rr = 0; rr < 4; rr++)
         for (int cc = 0; cc < 4; cc++) begin
            exp_a_q.push_back(7'(64 + rr * 8 + cc));
            exp_q.push_back(8'hFF);
         end
      check_writes("sat");
      n_cmp++;
      if (lc_q.size() !== 1 || lc_q[0] !== 16 || dc_q.size() !== 1 || dc_q[0] !== 67) begin
         n_fail++; $display("FAIL sat_status: got %0d levels %0d dones want count 16 done at 67",
                            lc_q.size(), dc_q.size());
      end
   endtask

   task automatic test_single_pixel();
      int hot[3] = '{81, 8, 64};
      fill(8'h00);
      mem[42] = 8'd7;
      run(1'b1, 4'd3);
      wait_done(200);
      for (int lvl = 1; lvl <= 3; lvl++)
         for (int rr = 0; rr < (8 >> lvl); rr++)
            for (int cc = 0; cc < (8 >> lvl); cc++) begin
               exp_a_q.push_back(7'((lvl % 2) * 64 + rr * 8 + cc));
               exp_q.push_back(((lvl % 2) * 64 + rr * 8 + cc) == hot[lvl - 1] ? 8'd1 : 8'd0);
            end
      check_writes("pixel");
      n_cmp++;
      if (lc_q.size() !== 3) begin
         n_fail++; $display("FAIL pixel_nlevels: got %0d want 3", lc_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (lc_q[i] !== 1) begin
               n_fail++; $display("FAIL pixel_count%0d: got %0d want 1", i + 1, lc_q[i]);
            end
         end
      end
   endtask

   task automatic test_start_while_busy();
      fill(8'h01);
      run(1'b0, 4'd0);
      repeat (19) @(negedge CLK);
      bus.start = 1'b1; bus.cfg_levels = 4'd1;
      @(negedge CLK);
      bus.start = 1'b0; bus.cfg_levels = 4'd3;
      wait_done(200);
      n_cmp++;
      if (li_q.size() !== 3 || dc_q.size() !== 1 || wa_q.size() !== 21) begin
         n_fail++; $display("FAIL busy_start: got %0d levels %0d dones %0d writes want 3 1 21",
                            li_q.size(), dc_q.size(), wa_q.size());
      end else begin
         n_cmp++;
         if (dc_q[0] !== 91 || lc_q[2] !== 1 || lvc_q[0] !== 66) begin
            n_fail++; $display("FAIL busy_timing: got done %0d cnt3 %0d lv1 %0d want 91 1 66",
                               dc_q[0], lc_q[2], lvc_q[0]);
         end
      end
   endtask

   task automatic test_abort();
      fill(8'h01);
      run(1'b0, 4'd3);
      repeat (75) @(negedge CLK);
      bus.abort = 1'b1;
      @(negedge CLK);
      bus.abort = 1'b0;
      n_cmp++;
      if ({bus.rd_en, bus.wr_en, bus.busy, bus.done} !== 4'b0 || bus.state_dbg !== 2'd0) begin
         n_fail++; $display("FAIL abort_outputs: got rd %b wr %b busy %b done %b st %0d want 0 0 0 0 0",
                            bus.rd_en, bus.wr_en, bus.busy, bus.done, bus.state_dbg);
      end
      repeat (40) @(negedge CLK);
      n_cmp++;
      if (dc_q.size() !== 0 || lvc_q.size() !== 1 || wa_q.size() !== 17) begin
         n_fail++; $display("FAIL abort_quiet: got %0d dones %0d levels %0d writes want 0 1 17",
                            dc_q.size(), lvc_q.size(), wa_q.size());
      end
      fill(8'h01);
      run(1'b0, 4'd1);
      wait_done(120);
      for (int rr = 0; rr < 4; rr++)
         for (int cc = 0; cc < 4; cc++) begin
            exp_a_q.push_back(7'(64 + rr * 8 + cc));
            exp_q.push_back(8'd4);
         end
      check_writes("after_abort");
      n_cmp++;
      if (dc_q.size() !== 1 || dc_q[0] !== 67) begin
         n_fail++; $display("FAIL after_abort_done: got %0d dones want 1 at 67", dc_q.size());
      end
   endtask

   task automatic test_reset_mid_read();
      fill(8'h01);
      run(1'b0, 4'd3);
      repeat (10) @(negedge CLK);
      #1 RST = 1'b1;
      #1;
      n_cmp++;
      if ({bus.rd_en, bus.wr_en, bus.busy, bus.done, bus.level_valid} !== 5'b0 ||
          bus.state_dbg !== 2'd0) begin
         n_fail++; $display("FAIL rst_mid_ctrl: got %b st %0d want 00000 0",
                            {bus.rd_en, bus.wr_en, bus.busy, bus.done, bus.level_valid}, bus.state_dbg);
      end
      n_cmp++;
      if (bus.rd_addr !== 7'd0 || bus.wr_addr !== 7'd0 || bus.wr_data !== 8'd0 ||
          bus.level_idx !== 4'd0 || bus.level_count !== 6'd0) begin
         n_fail++; $display("FAIL rst_mid_data: got ra %0d wa %0d wd %0d idx %0d cnt %0d want all 0",
                            bus.rd_addr, bus.wr_addr, bus.wr_data, bus.level_idx, bus.level_count);
      end
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
   endtask

   initial begin
      cyc = 0; base = 0; n_cmp = 0; n_fail = 0;
      test_reset();
      test_ones_sum();
      test_saturate();
      test_single_pixel();
      test_start_while_busy();
      test_abort();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
